// File: rtl/load_store_unit_if.sv
// Bundles the request, response and DataMem signals of the load/store unit.
// The unit itself connects through the slave modport; the requester-side
// environment (execute stage, DataMem model) uses the master modport.
interface load_store_unit_if #(
    parameter int N = 32
);
    // Request channel
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [1:0]   req_size;
    logic         req_unsigned;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;

    // Response channel
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_rdata;
    logic         rsp_err;

    // DataMem port (word-only, big-endian)
    logic         mem_readEn;
    logic         mem_writeEn;
    logic [N-1:0] mem_address;
    logic [N-1:0] mem_datain;
    logic [N-1:0] mem_dataout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready,
        input  mem_dataout,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_readEn, mem_writeEn, mem_address, mem_datain
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready,
        output mem_dataout,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_readEn, mem_writeEn, mem_address, mem_datain
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: sole master of the word-only, big-endian DataMem port.
// Converts byte/half/word loads and stores into word accesses, extends load
// data, performs read-modify-write for sub-word stores and rejects
// misaligned or illegal requests without touching memory.
// Only N == 32 is supported; lane positions below assume a 32-bit word.
module load_store_unit #(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rstn,
    load_store_unit_if.slave  bus
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        ERR,
        RESP
    } state_t;

    state_t      state;

    // Request fields captured at the accept edge
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;   // only the low half is ever merged into memory

    logic        misaligned;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [N-1:0] load_ext;
    logic [N-1:0] store_merged;

    // Classify the incoming request as misaligned/illegal.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        misaligned = 1'b0;
        case (bus.req_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = bus.req_addr[0];
            SIZE_WORD: misaligned = |bus.req_addr[1:0];
            default:   misaligned = 1'b1;
        endcase
    end

    // Pick the addressed big-endian lanes out of the word being read.
    always_comb begin
        sel_byte = bus.mem_dataout[31:24];
        case (lane_q)
            2'd0:    sel_byte = bus.mem_dataout[31:24];
            2'd1:    sel_byte = bus.mem_dataout[23:16];
            2'd2:    sel_byte = bus.mem_dataout[15:8];
            default: sel_byte = bus.mem_dataout[7:0];
        endcase
        sel_half = lane_q[1] ? bus.mem_dataout[15:0] : bus.mem_dataout[31:16];
    end

    // Sign- or zero-extend the selected lane; word loads pass straight through.
    always_comb begin
        load_ext = bus.mem_dataout;
        case (size_q)
            SIZE_BYTE: load_ext = uns_q ? {24'h0, sel_byte}
                                        : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: load_ext = uns_q ? {16'h0, sel_half}
                                        : {{16{sel_half[15]}}, sel_half};
            default:   load_ext = bus.mem_dataout;
        endcase
    end

    // Replace only the addressed lane(s) of the read word with store data.
    always_comb begin
        store_merged = bus.mem_dataout;
        case (size_q)
            SIZE_BYTE: begin
                case (lane_q)
                    2'd0:    store_merged[31:24] = wdata_q[7:0];
                    2'd1:    store_merged[23:16] = wdata_q[7:0];
                    2'd2:    store_merged[15:8]  = wdata_q[7:0];
                    default: store_merged[7:0]   = wdata_q[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane_q[1]) store_merged[15:0]  = wdata_q;
                else           store_merged[31:16] = wdata_q;
            end
            default: store_merged = bus.mem_dataout;
        endcase
    end

    // Control FSM with registered handshake and DataMem outputs.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            state           <= IDLE;
            we_q            <= 1'b0;
            size_q          <= SIZE_BYTE;
            uns_q           <= 1'b0;
            lane_q          <= 2'd0;
            wdata_q         <= 16'h0;
            bus.req_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.mem_readEn  <= 1'b0;
            bus.mem_writeEn <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_datain  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        we_q          <= bus.req_we;
                        size_q        <= bus.req_size;
                        uns_q         <= bus.req_unsigned;
                        lane_q        <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        if (misaligned) begin
                            state <= ERR;
                        end else if (bus.req_we && (bus.req_size == SIZE_WORD)) begin
                            // Full-word store needs no read; write directly.
                            state           <= WR;
                            bus.mem_writeEn <= 1'b1;
                            bus.mem_address <= {bus.req_addr[N-1:2], 2'b00};
                            bus.mem_datain  <= bus.req_wdata;
                        end else begin
                            state           <= RD;
                            bus.mem_readEn  <= 1'b1;
                            bus.mem_address <= {bus.req_addr[N-1:2], 2'b00};
                        end
                    end
                end

                RD: begin
                    bus.mem_readEn <= 1'b0;
                    if (we_q) begin
                        // Sub-word store: write back the merged word, same address.
                        state           <= WR;
                        bus.mem_writeEn <= 1'b1;
                        bus.mem_datain  <= store_merged;
                    end else begin
                        state           <= RESP;
                        bus.mem_address <= '0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= load_ext;
                    end
                end

                WR: begin
                    state           <= RESP;
                    bus.mem_writeEn <= 1'b0;
                    bus.mem_address <= '0;
                    bus.mem_datain  <= '0;
                    bus.rsp_valid   <= 1'b1;
                    bus.rsp_rdata   <= '0;
                end

                ERR: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_rdata <= '0;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.req_ready <= 1'b1;
                    end
                end

                default: begin
                    state           <= IDLE;
                    bus.req_ready   <= 1'b1;
                    bus.rsp_valid   <= 1'b0;
                    bus.rsp_err     <= 1'b0;
                    bus.rsp_rdata   <= '0;
                    bus.mem_readEn  <= 1'b0;
                    bus.mem_writeEn <= 1'b0;
                    bus.mem_address <= '0;
                    bus.mem_datain  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of request vectors with
// constant expected results, a scoreboard queue of pending responses, a
// behavioural word memory, and hand-written sequences for back-pressure and
// reset during a read-modify-write.
module tb_load_store_unit;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    load_store_unit_if #(.N(32)) bus ();

    load_store_unit #(.N(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural DataMem: combinational read, write on the clock edge.
    logic [31:0] mem [0:63];
    assign bus.mem_dataout = mem[bus.mem_address[7:2]];

    int rd_cnt = 0;
    int wr_cnt = 0;

    always @(posedge clk) begin
        if (bus.mem_writeEn) mem[bus.mem_address[7:2]] = bus.mem_datain;
        if (bus.mem_readEn)  rd_cnt = rd_cnt + 1;
        if (bus.mem_writeEn) wr_cnt = wr_cnt + 1;
    end

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // negedges after the accept edge until rsp_valid is seen
        int          exp_rd;    // readEn cycles for this request
        int          exp_wr;    // writeEn cycles for this request
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_rd, input int exp_wr);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        return v;
    endfunction

    // Wait (bounded) for a negedge at which the unit is ready for a request.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check({name, " req_ready timeout"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    // Wait (bounded) for rsp_valid; lat counts negedges after the accept edge.
    task automatic wait_rsp(input string name, output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) check({name, " rsp_valid timeout"}, {31'b0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_valid    = 1'b1;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat});
    endtask

    task automatic compare_rsp(input string name, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({name, " latency"},   lat,                   e.lat);
        check({name, " rsp_rdata"}, bus.rsp_rdata,         e.rdata);
        check({name, " rsp_err"},   {31'b0, bus.rsp_err},  {31'b0, e.err});
    endtask

    // Full transaction with rsp_ready held high.
    task automatic run_vec(input vec_t v);
        int lat, rd0, wr0;
        wait_ready(v.name);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        drive_req(v);
        @(posedge clk);             // accept edge T
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(v.name, lat);
        compare_rsp(v.name, lat);
        @(posedge clk);             // response handshake
        @(negedge clk);
        check({v.name, " rsp_valid dropped"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({v.name, " readEn cycles"},  rd_cnt - rd0, v.exp_rd);
        check({v.name, " writeEn cycles"}, wr_cnt - wr0, v.exp_wr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},   {31'b0, bus.req_ready},   32'd1);
        check({tag, " rsp_valid"},   {31'b0, bus.rsp_valid},   32'd0);
        check({tag, " rsp_err"},     {31'b0, bus.rsp_err},     32'd0);
        check({tag, " rsp_rdata"},   bus.rsp_rdata,            32'd0);
        check({tag, " readEn"},      {31'b0, bus.mem_readEn},  32'd0);
        check({tag, " writeEn"},     {31'b0, bus.mem_writeEn}, 32'd0);
        check({tag, " mem_address"}, bus.mem_address,          32'd0);
        check({tag, " mem_datain"},  bus.mem_datain,           32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int   lat, rd0, wr0;
        vec_t v;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[32'h10 >> 2] = 32'h8899AABB;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b1;

        //          name       we size   uns addr      wdata         rdata         err lat rd wr
        vecs.push_back(mk("lb_11",   0, 2'b00, 0, 32'h11, 32'h0,        32'hFFFFFF99, 0, 2, 1, 0));
        vecs.push_back(mk("lbu_11",  0, 2'b00, 1, 32'h11, 32'h0,        32'h00000099, 0, 2, 1, 0));
        vecs.push_back(mk("lb_13",   0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFFBB, 0, 2, 1, 0));
        vecs.push_back(mk("lbu_10",  0, 2'b00, 1, 32'h10, 32'h0,        32'h00000088, 0, 2, 1, 0));
        vecs.push_back(mk("lh_10",   0, 2'b01, 0, 32'h10, 32'h0,        32'hFFFF8899, 0, 2, 1, 0));
        vecs.push_back(mk("lhu_12",  0, 2'b01, 1, 32'h12, 32'h0,        32'h0000AABB, 0, 2, 1, 0));
        vecs.push_back(mk("lh_12",   0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFAABB, 0, 2, 1, 0));
        vecs.push_back(mk("sh_12",   1, 2'b01, 0, 32'h12, 32'h00001234, 32'h0,        0, 3, 1, 1));
        vecs.push_back(mk("lw_10",   0, 2'b10, 1, 32'h10, 32'h0,        32'h88991234, 0, 2, 1, 0));
        vecs.push_back(mk("lh_13",   0, 2'b01, 0, 32'h13, 32'h0,        32'h0,        1, 2, 0, 0));
        vecs.push_back(mk("lw_11",   0, 2'b10, 0, 32'h11, 32'h0,        32'h0,        1, 2, 0, 0));
        vecs.push_back(mk("sw_22",   1, 2'b10, 0, 32'h22, 32'hDEADBEEF, 32'h0,        1, 2, 0, 0));
        vecs.push_back(mk("size_11", 0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 2, 0, 0));
        vecs.push_back(mk("sw_20",   1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk("lw_20",   0, 2'b10, 0, 32'h20, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0));
        vecs.push_back(mk("sb_23",   1, 2'b00, 0, 32'h23, 32'h0000007F, 32'h0,        0, 3, 1, 1));
        vecs.push_back(mk("lw_20b",  0, 2'b10, 0, 32'h20, 32'h0,        32'hDEADBE7F, 0, 2, 1, 0));
        vecs.push_back(mk("sb_20",   1, 2'b00, 0, 32'h20, 32'hFFFFFF80, 32'h0,        0, 3, 1, 1));
        vecs.push_back(mk("lw_20c",  0, 2'b10, 0, 32'h20, 32'h0,        32'h80ADBE7F, 0, 2, 1, 0));
        vecs.push_back(mk("lb_20",   0, 2'b00, 0, 32'h20, 32'h0,        32'hFFFFFF80, 0, 2, 1, 0));
        vecs.push_back(mk("lbu_22",  0, 2'b00, 1, 32'h22, 32'h0,        32'h000000BE, 0, 2, 1, 0));
        vecs.push_back(mk("lh_22",   0, 2'b01, 0, 32'h22, 32'h0,        32'hFFFFBE7F, 0, 2, 1, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset req_ready", {31'b0, bus.req_ready}, 32'd1);

        // Table-driven vectors
        foreach (vecs[i]) run_vec(vecs[i]);
        check("mem 0x10 after sh", mem[32'h10 >> 2], 32'h88991234);
        check("mem 0x20 after sb", mem[32'h20 >> 2], 32'h80ADBE7F);

        // Back-pressure: hold rsp_ready low for 5 cycles on an LW, with a
        // second request waiting that must not be accepted until the handshake.
        wait_ready("hold");
        bus.rsp_ready = 1'b0;
        v = mk("hold_lw", 0, 2'b10, 0, 32'h20, 32'h0, 32'h80ADBE7F, 0, 2, 1, 0);
        drive_req(v);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp("hold_lw", lat);
        compare_rsp("hold_lw", lat);
        v = mk("hold_lbu", 0, 2'b00, 1, 32'h21, 32'h0, 32'h000000AD, 0, 2, 1, 0);
        drive_req(v);
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("hold rsp_rdata", bus.rsp_rdata, 32'h80ADBE7F);
            check("hold rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
            check("hold req_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        check("hold no access", rd_cnt - rd0, 32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);             // handshake of the LW
        @(negedge clk);
        check("after hs req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("after hs rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge clk);             // second request accepted here
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("second accepted", {31'b0, bus.req_ready}, 32'd0);
        wait_rsp("hold_lbu", lat);
        compare_rsp("hold_lbu", lat);
        @(posedge clk);
        @(negedge clk);
        check("hold_lbu readEn cycles", rd_cnt - rd0, 32'd1);

        // Reset asserted while the write cycle of an SH is active
        wait_ready("rst_sh");
        wr0 = wr_cnt;
        v = mk("rst_sh", 1, 2'b01, 0, 32'h12, 32'h00005555, 32'h0, 0, 3, 1, 1);
        drive_req(v);
        void'(sb.pop_front());      // this request never completes
        @(posedge clk);             // accept; RD follows
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_sh in RD readEn", {31'b0, bus.mem_readEn}, 32'd1);
        @(posedge clk);             // RD -> WR
        @(negedge clk);
        check("rst_sh in WR writeEn", {31'b0, bus.mem_writeEn}, 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_wr_reset");
        @(posedge clk);
        @(negedge clk);
        check("mid_wr_reset mem unchanged", mem[32'h10 >> 2], 32'h88991234);
        check("mid_wr_reset no write", wr_cnt - wr0, 32'd0);
        rstn = 1'b1;
        run_vec(mk("lw_10_after_rst", 0, 2'b10, 0, 32'h10, 32'h0, 32'h88991234, 0, 2, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
